// File: rtl/keypad_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_pkg : scanner state encoding, key map and row decode helpers
// Rev 1.0
// ------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE_P = 2'd1,
        PRESSED    = 2'd2,
        DEBOUNCE_R = 2'd3
    } state_t;

    // Indexed [row][col]
    localparam logic [3:0] c_keymap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic one_low(input logic [3:0] rows);
        return ($countones(~rows) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_scan_if : keypad pins and decoded digit outputs
// Rev 1.0
// ------------------------------------------------------------------
interface keypad_scan_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] value1;
    logic [3:0] value2;
    logic       key_valid;

    modport master (input rows, output cols, output value1, output value2, output key_valid);
    modport slave  (output rows, input cols, input value1, input value2, input key_valid);
endinterface
`default_nettype wire

// File: rtl/keypad_scan_sync_2ff.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with parameterised reset value
// Rev 1.0
// ------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_scan : 4x4 keypad column scanner with press/release debounce
// Rev 1.0
// ------------------------------------------------------------------
import keypad_pkg::*;

module keypad_scan #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    keypad_scan_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT);

    state_t             r_state;
    state_t             w_state_next;
    logic [DIV_W-1:0]   r_div;
    logic [DEB_W-1:0]   r_deb;
    logic [1:0]         r_col;
    logic [1:0]         r_row;
    logic [3:0]         r_pat;
    logic [3:0]         r_value1;
    logic [3:0]         r_value2;
    logic               r_key_valid;
    logic [3:0]         w_rows_s;
    logic               w_dwell_done;
    logic               w_one_low;
    logic               w_match;
    logic               w_deb_done;
    logic               w_released;
    logic               w_capture;
    logic               w_advance;
    logic               w_register;
    logic [3:0]         w_cols;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.rows),
        .q     (w_rows_s)
    );

    assign w_dwell_done = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_one_low    = one_low(w_rows_s);
    assign w_match      = (w_rows_s == r_pat);
    assign w_deb_done   = (r_deb == DEB_W'(DEBOUNCE_CNT - 1));
    assign w_released   = (w_rows_s == 4'b1111);

    always_ff @(posedge clk) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCAN:       if (w_dwell_done && w_one_low) w_state_next = DEBOUNCE_P;
            DEBOUNCE_P: if (!w_match)                  w_state_next = SCAN;
                        else if (w_deb_done)           w_state_next = PRESSED;
            PRESSED:    if (w_released)                w_state_next = DEBOUNCE_R;
            DEBOUNCE_R: if (!w_released)               w_state_next = PRESSED;
                        else if (w_deb_done)           w_state_next = SCAN;
            default:                                   w_state_next = SCAN;
        endcase
    end

    // The column only moves while scanning or when a debounce attempt ends;
    // it stays locked from capture through release so chords cannot alias.
    always_comb begin
        w_capture  = (r_state == SCAN) && w_dwell_done && w_one_low;
        w_advance  = ((r_state == SCAN)       && w_dwell_done && !w_one_low) ||
                     ((r_state == DEBOUNCE_P) && !w_match) ||
                     ((r_state == DEBOUNCE_R) && w_released && w_deb_done);
        w_register = (r_state == DEBOUNCE_P) && w_match && w_deb_done;
        w_cols     = ~(4'b0001 << r_col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_deb       <= '0;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_pat       <= 4'b1111;
            r_value1    <= 4'h0;
            r_value2    <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_register;

            if (r_state != SCAN || w_dwell_done) r_div <= '0;
            else                                 r_div <= r_div + 1'b1;

            if (w_state_next != r_state)
                r_deb <= '0;
            else if (r_state == DEBOUNCE_P || r_state == DEBOUNCE_R)
                r_deb <= r_deb + 1'b1;

            if (w_advance) r_col <= r_col + 2'd1;

            if (w_capture) begin
                r_row <= low_index(w_rows_s);
                r_pat <= w_rows_s;
            end

            if (w_register) begin
                r_value1 <= r_value2;
                r_value2 <= c_keymap[r_row][r_col];
            end
        end
    end

    assign kp.cols      = w_cols;
    assign kp.value1    = r_value1;
    assign kp.value2    = r_value2;
    assign kp.key_valid = r_key_valid;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_keypad_scan : directed bench with a behavioural 4x4 key matrix
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_scan;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [3:0][3:0]  pressed = '0;   // [row][col]
    logic [3:0]       w_rows;
    int               n_vec  = 0;
    int               n_err  = 0;
    int               pulses = 0;

    keypad_scan_if bus ();

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (bus.master)
    );

    always #5 clk = ~clk;

    // A pressed switch shorts its row to its column while that column is driven low
    always_comb begin
        w_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !bus.cols[c]) w_rows[r] = 1'b0;
    end
    assign bus.rows = w_rows;

    always @(posedge clk) if (bus.key_valid === 1'b1) pulses <= pulses + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic wait_kv(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_cols;
        pressed = '0;
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        n_vec += 4;
        if (bus.cols !== 4'b1110) begin n_err++; $display("FAIL reset_cols: got %b expected 1110", bus.cols); end
        if (bus.value1 !== 4'h0) begin n_err++; $display("FAIL reset_value1: got %h expected 0", bus.value1); end
        if (bus.value2 !== 4'h0) begin n_err++; $display("FAIL reset_value2: got %h expected 0", bus.value2); end
        if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_kv: got %b expected 0", bus.key_valid); end
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_cols = ~(4'b0001 << ((n / 4) % 4));
            n_vec += 2;
            if (bus.cols !== exp_cols) begin n_err++; $display("FAIL idle_cols[%0d]: got %b expected %b", n, bus.cols, exp_cols); end
            if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL idle_kv[%0d]: got %b expected 0", n, bus.key_valid); end
        end
        n_vec += 2;
        if (bus.value1 !== 4'h0 || bus.value2 !== 4'h0) begin
            n_err++; $display("FAIL idle_values: got %h/%h expected 0/0", bus.value1, bus.value2);
        end
        if (pulses !== 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    endtask

    // Key 6 held through reset: column 2 is first driven after edge 8, sampled at
    // edge 12, then 8 matching debounce cycles put key_valid in the cycle after edge 20.
    task automatic test_press_latency;
        int base;
        @(negedge clk);
        reset = 1'b1;
        pressed = '0;
        pressed[1][2] = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            n_vec++;
            if (bus.key_valid !== (n == 20)) begin
                n_err++; $display("FAIL latency_kv[%0d]: got %b expected %b", n, bus.key_valid, (n == 20));
            end
        end
        n_vec += 3;
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL press_value2: got %h expected 6", bus.value2); end
        if (bus.value1 !== 4'h0) begin n_err++; $display("FAIL press_value1: got %h expected 0", bus.value1); end
        if (bus.cols !== 4'b1011) begin n_err++; $display("FAIL press_cols: got %b expected 1011", bus.cols); end
        base = pulses;
        n_vec++;
        if (base !== 1) begin n_err++; $display("FAIL press_pulses: got %0d expected 1", base); end
        cycles(30);
        n_vec += 2;
        if (bus.cols !== 4'b1011) begin n_err++; $display("FAIL held_cols: got %b expected 1011", bus.cols); end
        if (pulses !== base) begin n_err++; $display("FAIL held_pulses: got %0d expected %0d", pulses, base); end
        pressed = '0;
        cycles(40);
        n_vec += 2;
        if (pulses !== base) begin n_err++; $display("FAIL release_pulses: got %0d expected %0d", pulses, base); end
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL release_value2: got %h expected 6", bus.value2); end
    endtask

    task automatic test_glitch;
        int base;
        bit seen;
        do_reset();
        base = pulses;
        repeat (10) begin
            pressed[1][2] = 1'b1; cycles(3);
            pressed[1][2] = 1'b0; cycles(3);
        end
        cycles(10);
        n_vec += 2;
        if (pulses !== base) begin n_err++; $display("FAIL glitch_pulses: got %0d expected %0d", pulses - base, 0); end
        if (bus.value2 !== 4'h0) begin n_err++; $display("FAIL glitch_value2: got %h expected 0", bus.value2); end
        pressed[1][2] = 1'b1;
        wait_kv(100, seen);
        n_vec += 3;
        if (seen !== 1'b1) begin n_err++; $display("FAIL glitch_stable_kv: got %b expected 1", seen); end
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL glitch_value2_after: got %h expected 6", bus.value2); end
        if (bus.value1 !== 4'h0) begin n_err++; $display("FAIL glitch_value1_after: got %h expected 0", bus.value1); end
        repeat (4) begin
            pressed[1][2] = 1'b0; cycles(3);
            pressed[1][2] = 1'b1; cycles(2);
        end
        pressed = '0;
        cycles(40);
        n_vec += 2;
        if (pulses !== base + 1) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 1", pulses - base); end
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL bounce_value2: got %h expected 6", bus.value2); end
    endtask

    task automatic test_sequence;
        int         kr [3] = '{1, 3, 0};
        int         kc [3] = '{2, 1, 3};
        logic [3:0] e1 [3] = '{4'h0, 4'h6, 4'h0};
        logic [3:0] e2 [3] = '{4'h6, 4'h0, 4'hA};
        int base;
        bit seen;
        do_reset();
        base = pulses;
        for (int k = 0; k < 3; k++) begin
            pressed[kr[k]][kc[k]] = 1'b1;
            wait_kv(100, seen);
            n_vec += 3;
            if (seen !== 1'b1) begin n_err++; $display("FAIL seq_kv[%0d]: got %b expected 1", k, seen); end
            if (bus.value1 !== e1[k]) begin n_err++; $display("FAIL seq_value1[%0d]: got %h expected %h", k, bus.value1, e1[k]); end
            if (bus.value2 !== e2[k]) begin n_err++; $display("FAIL seq_value2[%0d]: got %h expected %h", k, bus.value2, e2[k]); end
            pressed = '0;
            cycles(30);
        end
        n_vec++;
        if (pulses - base !== 3) begin n_err++; $display("FAIL seq_pulses: got %0d expected 3", pulses - base); end
    endtask

    task automatic test_chord;
        int base;
        bit seen;
        do_reset();
        base = pulses;
        pressed[1][2] = 1'b1;
        wait_kv(100, seen);
        n_vec++;
        if (seen !== 1'b1) begin n_err++; $display("FAIL chord_first_kv: got %b expected 1", seen); end
        pressed[0][1] = 1'b1;
        cycles(30);
        n_vec += 2;
        if (pulses !== base + 1) begin n_err++; $display("FAIL chord_held_pulses: got %0d expected 1", pulses - base); end
        if (bus.cols !== 4'b1011) begin n_err++; $display("FAIL chord_cols: got %b expected 1011", bus.cols); end
        pressed = '0;
        cycles(30);
        n_vec += 2;
        if (pulses !== base + 1) begin n_err++; $display("FAIL chord_release_pulses: got %0d expected 1", pulses - base); end
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL chord_value2: got %h expected 6", bus.value2); end
        pressed[0][1] = 1'b1;
        wait_kv(100, seen);
        n_vec += 3;
        if (seen !== 1'b1) begin n_err++; $display("FAIL chord_second_kv: got %b expected 1", seen); end
        if (bus.value2 !== 4'h2) begin n_err++; $display("FAIL chord_second_value2: got %h expected 2", bus.value2); end
        if (bus.value1 !== 4'h6) begin n_err++; $display("FAIL chord_second_value1: got %h expected 6", bus.value1); end
        pressed = '0;
        cycles(30);
    endtask

    task automatic test_reset_mid;
        int base;
        bit seen;
        do_reset();
        pressed[1][2] = 1'b1;
        wait_kv(100, seen);
        cycles(5);
        n_vec += 2;
        if (seen !== 1'b1) begin n_err++; $display("FAIL mid_kv: got %b expected 1", seen); end
        if (bus.value2 !== 4'h6) begin n_err++; $display("FAIL mid_value2_pre: got %h expected 6", bus.value2); end
        base = pulses;
        reset = 1'b1;
        @(negedge clk);
        n_vec += 4;
        if (bus.value1 !== 4'h0) begin n_err++; $display("FAIL mid_value1: got %h expected 0", bus.value1); end
        if (bus.value2 !== 4'h0) begin n_err++; $display("FAIL mid_value2: got %h expected 0", bus.value2); end
        if (bus.cols !== 4'b1110) begin n_err++; $display("FAIL mid_cols: got %b expected 1110", bus.cols); end
        if (bus.key_valid !== 1'b0) begin n_err++; $display("FAIL mid_kv_low: got %b expected 0", bus.key_valid); end
        cycles(3);
        pressed = '0;
        reset = 1'b0;
        cycles(10);
        n_vec++;
        if (pulses !== base) begin n_err++; $display("FAIL mid_pulses: got %0d expected 0", pulses - base); end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_sequence();
        test_chord();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
`default_nettype wire

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Scans a 4x4 matrix keypad, debounces presses and releases, and records the two most recent hex keys. It sits directly upstream of the dual seven-segment writer and drives its value1/value2 inputs. One registered key per physical press; held keys and multi-key chords never double-register.

Parameters:
SCAN_DIV, 16, clock cycles each column is driven before its rows are sampled (>=4).
DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release (>=2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk
cols  output  4  keypad column drive, active-low, exactly one bit low at all times
value1  output  4  older key code (left digit)
value2  output  4  most recent key code (right digit)
key_valid  output  1  one-cycle pulse when a new key is registered

Behaviour:
- Single clock domain; all state updates on posedge clk; reset is synchronous and active-high.
- rows passes through a 2-flop synchronizer (reset 4'b1111) before any use; rows_s = synchronizer output.
- Reset values: state=SCAN, column index 0 (cols=4'b1110), value1=value2=4'h0, key_valid=0, all counters 0.
- Key map (row,col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- SCAN: drive current column for SCAN_DIV cycles; on the final cycle sample rows_s. Exactly one row low -> latch row/col, clear debounce counter, go DEBOUNCE_P, and hold the column. Zero or >=2 rows low -> advance column (3 wraps to 0), restart dwell counter.
- DEBOUNCE_P: column held. Each cycle rows_s equals the latched one-low pattern -> counter+1; any mismatch -> return SCAN with next column. Counter reaches DEBOUNCE_CNT-1 with a match -> go PRESSED.
- PRESSED entry cycle (single cycle): value1<=value2, value2<=keymap(row,col), key_valid=1 the next cycle only. Stay in PRESSED while any row_s is low; all rows high -> DEBOUNCE_R, counter cleared.
- DEBOUNCE_R: rows_s==4'b1111 for DEBOUNCE_CNT consecutive cycles -> SCAN (column advances). Any row low -> back to PRESSED without re-registering.
- Second key pressed while one is held: ignored (column locked); the second key registers only after release and a fresh scan.
- Press shorter than DEBOUNCE_CNT cycles: nothing registered; values unchanged, no key_valid.
- Latency: stable press sampled at cycle t -> key_valid at t + DEBOUNCE_CNT + 1 (+2 synchronizer cycles from pin).
- Counters sized with $clog2 of their parameter; no overflow since each clears on every state change.
- Reset asserted mid-operation (any state): next edge restores all reset values; no key_valid pulse.
- value1/value2 are registered and change only on the PRESSED entry cycle; glitch-free to the display.

Decomposition:
- keypad_pkg: state enum (SCAN, DEBOUNCE_P, PRESSED, DEBOUNCE_R), 4x4 keymap constant array, and a one-hot-low row check function.
- Sub-module sync_2ff (4-bit, reset value parameter) for the rows synchronizer; FSM, counters and digit registers remain in keypad_scan.

Test Plan:
- (SCAN_DIV=4, DEBOUNCE_CNT=8) Reset, idle rows=1111 for 40 cycles -> cols cycles 1110,1101,1011,0111 every 4 cycles; value1=value2=0; no key_valid.
- Press row1/col2 (key 6) stably -> exactly one key_valid; value2=6, value1=0; cols frozen at 1011 while held.
- Press row1/col2 with 3-cycle low glitches during debounce -> no registration until 8 stable cycles; release bounces during DEBOUNCE_R -> no second pulse.
- Sequence 6, then 0 (row3/col1), then A (row0/col3) -> value1/value2 = 0/6, then 6/0, then 0/A; three pulses total.
- Hold key 6 and press key 2 simultaneously, then release both -> only 6 registered; pressing 2 alone afterward registers 2.
- Assert reset during PRESSED with value2=6 -> next cycle values=0, cols=1110, state SCAN, key_valid=0.
